risc_ctrl_sequencer: RTL and testbench

- Clocked, synthesizable hardwired control sequencer for the 32-bit RISC datapath.
- Replaces the delay-based control unit with one state per Clock cycle.
- Adds a full opcode decode, memory wait-state handshake with timeout, Stop-to-halt, and fault reporting.
- Drives the bus/register strobes as a packed control word plus ALU operation code.

---
 rtl/risc_ctrl_sequencer_if.sv | 26 ++
 rtl/risc_ctrl_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_risc_ctrl_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_ctrl_sequencer_if.sv
// Bus bundle between the control sequencer and the 32-bit RISC datapath.
// The datapath side drives the instruction and status inputs; the sequencer drives the strobes.
interface risc_ctrl_sequencer_if #(
  parameter int IR_W  = 32,
  parameter int ALU_W = 5
);
  logic [IR_W-1:0]  IR;
  logic             CON_FF;
  logic             MemReady;
  logic             Stop;
  logic [26:0]      Ctrl;
  logic [ALU_W-1:0] ALUCode;
  logic             Run;
  logic             Fault;
  logic [5:0]       State;

  modport master (
    output IR, CON_FF, MemReady, Stop,
    input  Ctrl, ALUCode, Run, Fault, State
  );

  modport slave (
    input  IR, CON_FF, MemReady, Stop,
    output Ctrl, ALUCode, Run, Fault, State
  );
endinterface

// File: rtl/risc_ctrl_sequencer.sv
// Hardwired one-state-per-cycle control sequencer: fetch, opcode decode, execute,
// memory wait states with timeout fault, and Stop-to-halt at instruction boundaries.
module risc_ctrl_sequencer #(
  parameter int IR_W     = 32,
  parameter int OPC_W    = 5,
  parameter int ALU_W    = 5,
  parameter bit WAIT_EN  = 1'b1,
  parameter int MAX_WAIT = 15
) (
  input logic                  Clock,
  input logic                  Reset,
  risc_ctrl_sequencer_if.slave bus
);

  typedef enum logic [5:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_LD   = opc_t'(0);
  localparam opc_t OP_LDI  = opc_t'(1);
  localparam opc_t OP_ST   = opc_t'(2);
  localparam opc_t OP_ADD  = opc_t'(3);
  localparam opc_t OP_ROL  = opc_t'(11);
  localparam opc_t OP_ADDI = opc_t'(12);
  localparam opc_t OP_ANDI = opc_t'(13);
  localparam opc_t OP_ORI  = opc_t'(14);
  localparam opc_t OP_MUL  = opc_t'(15);
  localparam opc_t OP_DIV  = opc_t'(16);
  localparam opc_t OP_NEG  = opc_t'(17);
  localparam opc_t OP_NOT  = opc_t'(18);
  localparam opc_t OP_BR   = opc_t'(19);
  localparam opc_t OP_JR   = opc_t'(20);
  localparam opc_t OP_JAL  = opc_t'(21);
  localparam opc_t OP_IN   = opc_t'(22);
  localparam opc_t OP_OUT  = opc_t'(23);
  localparam opc_t OP_MFHI = opc_t'(24);
  localparam opc_t OP_MFLO = opc_t'(25);
  localparam opc_t OP_HALT = opc_t'(27);

  localparam logic [26:0] GRA  = 27'd1 << 0,  GRB   = 27'd1 << 1,  GRC   = 27'd1 << 2;
  localparam logic [26:0] RIN  = 27'd1 << 3,  ROUT  = 27'd1 << 4,  BAOUT = 27'd1 << 5;
  localparam logic [26:0] CONIN = 27'd1 << 6, HIIN  = 27'd1 << 7,  LOIN  = 27'd1 << 8;
  localparam logic [26:0] ZIN  = 27'd1 << 9,  PCIN  = 27'd1 << 10, MDRIN = 27'd1 << 11;
  localparam logic [26:0] MARIN = 27'd1 << 12, YIN  = 27'd1 << 13, OUTIN = 27'd1 << 14;
  localparam logic [26:0] IRIN = 27'd1 << 15, HIOUT = 27'd1 << 16, LOOUT = 27'd1 << 17;
  localparam logic [26:0] ZHI  = 27'd1 << 18, ZLO   = 27'd1 << 19, PCOUT = 27'd1 << 20;
  localparam logic [26:0] MDROUT = 27'd1 << 21, INOUT = 27'd1 << 22, COUT = 27'd1 << 23;
  localparam logic [26:0] READ = 27'd1 << 24, WRITE = 27'd1 << 25, CLEAR = 27'd1 << 26;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t           state_q, state_d, last_st;
  opc_t             opc_q, opc_d, ir_opc, opc_x;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d, fault_q, fault_d, stop_seen, mem_state;
  logic             is_alu, is_imm, is_md, is_un;
  logic [26:0]      ctrl_c;
  logic [ALU_W-1:0] alu_c;
  logic             run_c;

  // IR is only reloaded at the end of T2, so it is valid live in T3; later states use the latched copy.
  assign ir_opc = bus.IR[IR_W-1 -: OPC_W];
  assign opc_x  = (state_q == S_T3) ? ir_opc : opc_q;

  assign is_alu = opc_x inside {[OP_ADD:OP_ROL]};
  assign is_imm = opc_x inside {[OP_ADDI:OP_ORI]};
  assign is_md  = (opc_x == OP_MUL) || (opc_x == OP_DIV);
  assign is_un  = (opc_x == OP_NEG) || (opc_x == OP_NOT);

  assign mem_state = (state_q == S_T1) || (state_q == S_T6 && opc_x == OP_LD) ||
                     (state_q == S_T7 && opc_x == OP_ST);

  always_comb begin
    if (is_alu || is_imm || opc_x == OP_LDI)          last_st = S_T5;
    else if (is_md || opc_x == OP_BR)                 last_st = S_T6;
    else if (opc_x == OP_LD || opc_x == OP_ST)        last_st = S_T7;
    else if (is_un || opc_x == OP_JAL)                last_st = S_T4;
    else                                              last_st = S_T3;
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = (state_q == S_T3) ? ir_opc : opc_q;
    cnt_d     = '0;
    fault_d   = fault_q;
    stop_seen = stop_q | bus.Stop;
    stop_d    = stop_seen;
    unique case (state_q)
      S_RESET: begin
        state_d = S_T0;
        stop_d  = 1'b0;
      end
      S_HALT: stop_d = 1'b0;
      default: begin
        if (mem_state && WAIT_EN && !bus.MemReady) begin
          if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == last_st) begin
          state_d = (stop_seen || (state_q == S_T3 && opc_x == OP_HALT)) ? S_HALT : S_T0;
          stop_d  = 1'b0;
        end else begin
          state_d = state_t'(state_q + 6'd1);
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RESET;
      opc_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    ctrl_c = '0;
    alu_c  = '0;
    run_c  = 1'b1;
    unique case (state_q)
      S_RESET: begin run_c = 1'b0; ctrl_c = CLEAR; end
      S_HALT:  run_c = 1'b0;
      S_T0:    begin ctrl_c = PCOUT | MARIN | ZIN; alu_c = '1; end
      S_T1:    ctrl_c = ZLO | PCIN | READ | MDRIN;
      S_T2:    ctrl_c = MDROUT | IRIN;
      default: begin
        if (is_alu || is_imm) begin
          if (state_q == S_T3) ctrl_c = GRB | ROUT | YIN;
          if (state_q == S_T4) begin
            ctrl_c = is_alu ? (GRC | ROUT | ZIN) : (COUT | ZIN);
            alu_c  = is_alu ? ALU_W'(opc_x) :
                     (opc_x == OP_ADDI) ? ALU_W'(3) : (opc_x == OP_ANDI) ? ALU_W'(5) : ALU_W'(6);
          end
          if (state_q == S_T5) ctrl_c = ZLO | GRA | RIN;
        end else if (is_md) begin
          if (state_q == S_T3) ctrl_c = GRA | ROUT | YIN;
          if (state_q == S_T4) begin ctrl_c = GRB | ROUT | ZIN; alu_c = ALU_W'(opc_x); end
          if (state_q == S_T5) ctrl_c = ZLO | LOIN;
          if (state_q == S_T6) ctrl_c = ZHI | HIIN;
        end else if (is_un) begin
          if (state_q == S_T3) begin ctrl_c = GRB | ROUT | ZIN; alu_c = ALU_W'(opc_x); end
          if (state_q == S_T4) ctrl_c = ZLO | GRA | RIN;
        end else if (opc_x == OP_LD || opc_x == OP_ST || opc_x == OP_LDI) begin
          if (state_q == S_T3) ctrl_c = GRB | BAOUT | YIN;
          if (state_q == S_T4) begin ctrl_c = COUT | ZIN; alu_c = ALU_W'(3); end
          if (state_q == S_T5) ctrl_c = (opc_x == OP_LDI) ? (ZLO | GRA | RIN) : (ZLO | MARIN);
          if (state_q == S_T6) ctrl_c = (opc_x == OP_LD) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
          if (state_q == S_T7) ctrl_c = (opc_x == OP_LD) ? (MDROUT | GRA | RIN) : (MDROUT | WRITE);
        end else if (opc_x == OP_BR) begin
          if (state_q == S_T3) ctrl_c = GRA | ROUT | CONIN;
          if (state_q == S_T4) ctrl_c = PCOUT | YIN;
          if (state_q == S_T5) begin ctrl_c = COUT | ZIN; alu_c = ALU_W'(3); end
          // The branch is taken on the condition as it stands during T6 itself.
          if (state_q == S_T6 && bus.CON_FF) ctrl_c = ZLO | PCIN;
        end else if (state_q == S_T3) begin
          unique case (opc_x)
            OP_JR:   ctrl_c = GRA | ROUT | PCIN;
            OP_JAL:  ctrl_c = PCOUT | GRB | RIN;
            OP_IN:   ctrl_c = INOUT | GRA | RIN;
            OP_OUT:  ctrl_c = GRA | ROUT | OUTIN;
            OP_MFHI: ctrl_c = HIOUT | GRA | RIN;
            OP_MFLO: ctrl_c = LOOUT | GRA | RIN;
            default: ctrl_c = '0;
          endcase
        end else if (opc_x == OP_JAL && state_q == S_T4) begin
          ctrl_c = GRA | ROUT | PCIN;
        end
      end
    endcase
  end

  // Reset blanks every strobe at once rather than waiting for the next edge.
  assign bus.Ctrl    = Reset ? '0 : ctrl_c;
  assign bus.ALUCode = Reset ? '0 : alu_c;
  assign bus.Run     = Reset ? 1'b0 : run_c;
  assign bus.Fault   = fault_q;
  assign bus.State   = state_q;

endmodule

// File: tb/tb_risc_ctrl_sequencer.sv
// Self-checking bench for risc_ctrl_sequencer: per-cycle strobe sequences generated
// from an opcode table model, with random stalls, branch conditions and instruction mix.
module tb_risc_ctrl_sequencer;
  localparam int MAX_WAIT = 15;

  localparam int B_GRA = 0, B_GRB = 1, B_GRC = 2, B_RIN = 3, B_ROUT = 4, B_BAOUT = 5;
  localparam int B_CONIN = 6, B_HIIN = 7, B_LOIN = 8, B_ZIN = 9, B_PCIN = 10, B_MDRIN = 11;
  localparam int B_MARIN = 12, B_YIN = 13, B_OUTIN = 14, B_IRIN = 15, B_HIOUT = 16;
  localparam int B_LOOUT = 17, B_ZHI = 18, B_ZLO = 19, B_PCOUT = 20, B_MDROUT = 21;
  localparam int B_INOUT = 22, B_COUT = 23, B_READ = 24, B_WRITE = 25, B_CLEAR = 26;

  logic Clock = 1'b0;
  logic Reset;

  risc_ctrl_sequencer_if #(.IR_W(32), .ALU_W(5)) bus ();

  risc_ctrl_sequencer #(
    .IR_W(32), .OPC_W(5), .ALU_W(5), .WAIT_EN(1'b1), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [26:0] ctrl;
    logic [4:0]  alu;
    logic        rdy;
    logic        con;
  } cyc_t;

  cyc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [26:0] m(int b0, int b1 = -1, int b2 = -1, int b3 = -1);
    logic [26:0] r = '0;
    if (b0 >= 0) r[b0] = 1'b1;
    if (b1 >= 0) r[b1] = 1'b1;
    if (b2 >= 0) r[b2] = 1'b1;
    if (b3 >= 0) r[b3] = 1'b1;
    return r;
  endfunction

  function automatic void push(logic [26:0] c, logic [4:0] a = 5'd0, int con = -1);
    cyc_t e;
    e.ctrl = c;
    e.alu  = a;
    e.rdy  = 1'($urandom_range(0, 1));
    e.con  = (con < 0) ? 1'($urandom_range(0, 1)) : 1'(con);
    exp_q.push_back(e);
  endfunction

  function automatic void push_mem(logic [26:0] c, int stalls);
    for (int k = 0; k <= stalls; k++) begin
      push(c);
      exp_q[exp_q.size()-1].rdy = (k == stalls);
    end
  endfunction

  // Expected cycle-by-cycle strobes for one whole instruction.
  function automatic void build(logic [4:0] op, bit con, int fst, int mst);
    push(m(B_PCOUT, B_MARIN, B_ZIN), 5'b11111);
    push_mem(m(B_ZLO, B_PCIN, B_READ, B_MDRIN), fst);
    push(m(B_MDROUT, B_IRIN));
    if (op >= 5'd3 && op <= 5'd11) begin
      push(m(B_GRB, B_ROUT, B_YIN));
      push(m(B_GRC, B_ROUT, B_ZIN), op);
      push(m(B_ZLO, B_GRA, B_RIN));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(m(B_GRB, B_ROUT, B_YIN));
      push(m(B_COUT, B_ZIN), (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6);
      push(m(B_ZLO, B_GRA, B_RIN));
    end else if (op == 5'd15 || op == 5'd16) begin
      push(m(B_GRA, B_ROUT, B_YIN));
      push(m(B_GRB, B_ROUT, B_ZIN), op);
      push(m(B_ZLO, B_LOIN));
      push(m(B_ZHI, B_HIIN));
    end else if (op == 5'd17 || op == 5'd18) begin
      push(m(B_GRB, B_ROUT, B_ZIN), op);
      push(m(B_ZLO, B_GRA, B_RIN));
    end else if (op <= 5'd2) begin
      push(m(B_GRB, B_BAOUT, B_YIN));
      push(m(B_COUT, B_ZIN), 5'd3);
      if (op == 5'd1) push(m(B_ZLO, B_GRA, B_RIN));
      else begin
        push(m(B_ZLO, B_MARIN));
        if (op == 5'd0) begin
          push_mem(m(B_READ, B_MDRIN), mst);
          push(m(B_MDROUT, B_GRA, B_RIN));
        end else begin
          push(m(B_GRA, B_ROUT, B_MDRIN));
          push_mem(m(B_MDROUT, B_WRITE), mst);
        end
      end
    end else if (op == 5'd19) begin
      push(m(B_GRA, B_ROUT, B_CONIN));
      push(m(B_PCOUT, B_YIN));
      push(m(B_COUT, B_ZIN), 5'd3);
      push(con ? m(B_ZLO, B_PCIN) : 27'd0, 5'd0, int'(con));
    end else if (op == 5'd20) push(m(B_GRA, B_ROUT, B_PCIN));
    else if (op == 5'd21) begin
      push(m(B_PCOUT, B_GRB, B_RIN));
      push(m(B_GRA, B_ROUT, B_PCIN));
    end
    else if (op == 5'd22) push(m(B_INOUT, B_GRA, B_RIN));
    else if (op == 5'd23) push(m(B_GRA, B_ROUT, B_OUTIN));
    else if (op == 5'd24) push(m(B_HIOUT, B_GRA, B_RIN));
    else if (op == 5'd25) push(m(B_LOOUT, B_GRA, B_RIN));
    else push(27'd0);
  endfunction

  task automatic do_reset();
    bus.Stop = 1'b0;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; bus.IR = '0; bus.CON_FF = 1'b0; bus.MemReady = 1'b1; bus.Stop = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if (bus.Ctrl !== 27'd0 || bus.ALUCode !== 5'd0 || bus.Run !== 1'b0 || bus.Fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: Ctrl=%h ALUCode=%h Run=%b Fault=%b, want all 0",
               bus.Ctrl, bus.ALUCode, bus.Run, bus.Fault);
    end
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.Ctrl !== m(B_CLEAR) || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear: Ctrl=%h Run=%b, want Ctrl=%h Run=0", bus.Ctrl, bus.Run, m(B_CLEAR));
    end
    @(posedge Clock); #1;
    checks++;
    if (bus.Ctrl !== m(B_PCOUT, B_MARIN, B_ZIN) || bus.ALUCode !== 5'b11111 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL reset_t0: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=1f Run=1",
               bus.Ctrl, bus.ALUCode, bus.Run, m(B_PCOUT, B_MARIN, B_ZIN));
    end
  endtask

  task automatic test_add();
    cyc_t e;
    int   i = 0;
    bus.IR = 32'h1800_0000;
    build(5'd3, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.MemReady = 1'b1; bus.CON_FF = e.con;
      @(negedge Clock);
      checks++;
      if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1) begin
        errors++;
        $display("FAIL add cyc%0d: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=%h Run=1",
                 i, bus.Ctrl, bus.ALUCode, bus.Run, e.ctrl, e.alu);
      end
      @(posedge Clock); #1; i++;
    end
    checks++;
    if (bus.Ctrl !== m(B_PCOUT, B_MARIN, B_ZIN) || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL add_next_t0: Ctrl=%h Run=%b, want Ctrl=%h Run=1",
               bus.Ctrl, bus.Run, m(B_PCOUT, B_MARIN, B_ZIN));
    end
  endtask

  task automatic test_branch();
    cyc_t e;
    int   i;
    for (int c = 0; c < 2; c++) begin
      bus.IR = {5'b10011, 27'($urandom)};
      build(5'd19, c[0], 0, 0);
      i = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bus.MemReady = e.rdy; bus.CON_FF = e.con;
        @(negedge Clock);
        checks++;
        if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1) begin
          errors++;
          $display("FAIL branch con=%0d cyc%0d: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=%h",
                   c, i, bus.Ctrl, bus.ALUCode, bus.Run, e.ctrl, e.alu);
        end
        @(posedge Clock); #1; i++;
      end
    end
  endtask

  task automatic test_ld_wait();
    cyc_t e;
    int   i = 0;
    bus.IR = {5'b00000, 27'($urandom)};
    build(5'd0, 1'b0, MAX_WAIT - 1, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.MemReady = e.rdy; bus.CON_FF = e.con;
      @(negedge Clock);
      checks++;
      if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1 || bus.Fault !== 1'b0) begin
        errors++;
        $display("FAIL ld_wait cyc%0d: Ctrl=%h ALUCode=%h Run=%b Fault=%b, want Ctrl=%h ALUCode=%h",
                 i, bus.Ctrl, bus.ALUCode, bus.Run, bus.Fault, e.ctrl, e.alu);
      end
      @(posedge Clock); #1; i++;
    end
  endtask

  task automatic test_timeout();
    cyc_t e;
    int   i = 0;
    bus.IR = {5'b00000, 27'($urandom)};
    build(5'd0, 1'b0, 0, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    for (int k = 0; k < MAX_WAIT; k++) begin
      push(m(B_READ, B_MDRIN));
      exp_q[exp_q.size()-1].rdy = 1'b0;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.MemReady = e.rdy; bus.CON_FF = e.con;
      @(negedge Clock);
      checks++;
      if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1 || bus.Fault !== 1'b0) begin
        errors++;
        $display("FAIL timeout cyc%0d: Ctrl=%h ALUCode=%h Run=%b Fault=%b, want Ctrl=%h ALUCode=%h Fault=0",
                 i, bus.Ctrl, bus.ALUCode, bus.Run, bus.Fault, e.ctrl, e.alu);
      end
      @(posedge Clock); #1; i++;
    end
    bus.MemReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.Fault !== 1'b1 || bus.Run !== 1'b0 || bus.Ctrl !== 27'd0) begin
        errors++;
        $display("FAIL timeout_halt k%0d: Fault=%b Run=%b Ctrl=%h, want Fault=1 Run=0 Ctrl=0",
                 k, bus.Fault, bus.Run, bus.Ctrl);
      end
      @(posedge Clock); #1;
    end
    Reset = 1'b1; #1;
    checks++;
    if (bus.Fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: Fault=%b, want 0", bus.Fault);
    end
    do_reset();
  endtask

  task automatic test_stop_mul();
    cyc_t e;
    int   i = 0;
    bus.IR = {5'b01111, 27'($urandom)};
    build(5'd15, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.MemReady = e.rdy; bus.CON_FF = e.con; bus.Stop = (i == 4);
      @(negedge Clock);
      checks++;
      if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1) begin
        errors++;
        $display("FAIL stop_mul cyc%0d: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=%h Run=1",
                 i, bus.Ctrl, bus.ALUCode, bus.Run, e.ctrl, e.alu);
      end
      @(posedge Clock); #1; i++;
    end
    bus.Stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.Run !== 1'b0 || bus.Ctrl !== 27'd0) begin
        errors++;
        $display("FAIL stop_halt k%0d: Run=%b Ctrl=%h, want Run=0 Ctrl=0", k, bus.Run, bus.Ctrl);
      end
      @(posedge Clock); #1;
    end
    Reset = 1'b1; #1;
    checks++;
    if (bus.Fault !== 1'b0 || bus.Run !== 1'b0 || bus.Ctrl !== 27'd0) begin
      errors++;
      $display("FAIL stop_reset: Fault=%b Run=%b Ctrl=%h, want 0 0 0", bus.Fault, bus.Run, bus.Ctrl);
    end
    do_reset();
  endtask

  task automatic test_undef_halt();
    cyc_t e;
    int   i;
    for (int t = 0; t < 2; t++) begin
      bus.IR = {(t == 0) ? 5'b11111 : 5'b11011, 27'($urandom)};
      build((t == 0) ? 5'd31 : 5'd27, 1'b0, 0, 0);
      i = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bus.MemReady = e.rdy; bus.CON_FF = e.con;
        @(negedge Clock);
        checks++;
        if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1) begin
          errors++;
          $display("FAIL undef_halt t%0d cyc%0d: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=%h",
                   t, i, bus.Ctrl, bus.ALUCode, bus.Run, e.ctrl, e.alu);
        end
        @(posedge Clock); #1; i++;
      end
      checks++;
      if (bus.Run !== (t == 0) || bus.Ctrl !== ((t == 0) ? m(B_PCOUT, B_MARIN, B_ZIN) : 27'd0)) begin
        errors++;
        $display("FAIL undef_halt_after t%0d: Run=%b Ctrl=%h, want Run=%0d", t, bus.Run, bus.Ctrl, t == 0);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_st();
    cyc_t e;
    bus.IR = {5'b00010, 27'($urandom)};
    build(5'd2, 1'b0, 0, 5);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      bus.MemReady = e.rdy; bus.CON_FF = e.con;
      @(negedge Clock);
      checks++;
      if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1) begin
        errors++;
        $display("FAIL st cyc%0d: Ctrl=%h ALUCode=%h Run=%b, want Ctrl=%h ALUCode=%h",
                 i, bus.Ctrl, bus.ALUCode, bus.Run, e.ctrl, e.alu);
      end
      if (i < 7) begin @(posedge Clock); #1; end
    end
    exp_q.delete();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (bus.Ctrl !== 27'd0 || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL st_mid_reset: Ctrl=%h Run=%b, want Ctrl=0 Run=0", bus.Ctrl, bus.Run);
    end
    do_reset();
  endtask

  task automatic test_random();
    cyc_t       e;
    int         i;
    logic [4:0] op;
    int         fst, mst;
    bit         con;
    for (int n = 0; n < 150; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      con = 1'($urandom_range(0, 1));
      fst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_WAIT - 1) : 0;
      mst = ($urandom_range(0, 1) == 0) ? $urandom_range(1, MAX_WAIT - 1) : 0;
      bus.IR = {op, 27'($urandom)};
      build(op, con, fst, mst);
      i = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bus.MemReady = e.rdy; bus.CON_FF = e.con;
        @(negedge Clock);
        checks++;
        if (bus.Ctrl !== e.ctrl || bus.ALUCode !== e.alu || bus.Run !== 1'b1 || bus.Fault !== 1'b0) begin
          errors++;
          $display("FAIL random n%0d op%0d cyc%0d: Ctrl=%h ALUCode=%h Run=%b Fault=%b, want Ctrl=%h ALUCode=%h",
                   n, op, i, bus.Ctrl, bus.ALUCode, bus.Run, bus.Fault, e.ctrl, e.alu);
        end
        @(posedge Clock); #1; i++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_ld_wait();
    test_timeout();
    test_stop_mul();
    test_undef_halt();
    test_reset_mid_st();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
